booth_multiplier_arbiter_module: RTL and testbench
==================================================

BOOTH_MULTIPLIER_ARBITER_MODULE -- requirements
Module: booth_multiplier_arbiter_module

Interface
REQ-001 The block SHALL have parameter CALC_CYCLES, default 2, meaning cycles operands are held stable at the multiplier input before the product is captured (legal range 1..15).
REQ-002 The block SHALL have port CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port Start_Sig  input  2  per-requester request level; bit n held high by requester n until it sees Done_Sig[n].
REQ-005 The block SHALL have ports A0, B0  input  8  each, requester 0 signed multiplicand/multiplier.
REQ-006 The block SHALL have ports A1, B1  input  8  each, requester 1 signed multiplicand/multiplier.
REQ-007 The block SHALL have port Done_Sig  output  2  one-cycle completion pulse to the served requester.
REQ-008 The block SHALL have port Product  output  16  registered signed product of the last completed operation.
REQ-009 The block SHALL have port Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 The block SHALL contain one shared combinational 8x8 signed Booth multiplier, fed only from internal operand registers.
REQ-011 The FSM SHALL have states IDLE, LOAD, CALC, DONE, CLEAR.
REQ-012 IDLE: if any Start_Sig bit is high, the block SHALL choose a grant and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-013 Grant rule: single request -> that requester; both high -> the requester not served last (round-robin pointer).
REQ-014 LOAD (1 cycle): the block SHALL latch the granted A/B into the operand registers, record the grant index, clear the cycle counter, and go to CALC.
REQ-015 CALC: the counter SHALL increment each cycle; after exactly CALC_CYCLES cycles in CALC the block SHALL register the multiplier output into Product and go to DONE.
REQ-016 DONE (1 cycle): Done_Sig[grant] SHALL be 1, the other bit 0; the round-robin pointer SHALL update to grant; next state CLEAR.
REQ-017 CLEAR (1 cycle): Done_Sig SHALL be 0; next state IDLE, so a requester dropping Start_Sig after Done is never re-served.
REQ-018 Latency: Start_Sig sampled high in IDLE at edge k -> Done_Sig high in cycle k+2+CALC_CYCLES (k+4 at default).
REQ-019 Arithmetic: Product SHALL equal the full 16-bit two's-complement result of signed A x signed B, no truncation or saturation.
REQ-020 Operand changes after LOAD SHALL NOT affect the in-flight result.
REQ-021 Start_Sig dropped before DONE: the operation SHALL complete and Done_Sig SHALL still pulse.
REQ-022 Start_Sig changes during LOAD/CALC/DONE/CLEAR SHALL NOT change the current grant; new requests wait for IDLE.
REQ-023 Product SHALL hold its value from one DONE until the next DONE.

Reset
REQ-024 RSTn low SHALL immediately force: state IDLE, Done_Sig 2'b00, Product 16'h0000, Busy 0, operand registers 0, counter 0, round-robin pointer = 1 (requester 0 wins the first tie).
REQ-025 Reset asserted mid-operation SHALL abort it with no Done_Sig pulse; after release the block SHALL behave as if freshly reset.

Verification
REQ-026 Single request: Start_Sig=2'b01, A0=8'd7, B0=8'd6 -> Done_Sig=2'b01 for one cycle 4 cycles after sampling, Product=16'd42, Busy high LOAD..CLEAR.
REQ-027 Signed corners: A1=-128,B1=-128 -> Product=16'h4000; A1=-128,B1=127 -> 16'hC080; A0=-1,B0=1 -> 16'hFFFF; A0=0,B0=-128 -> 16'h0000.
REQ-028 Tie after reset: Start_Sig=2'b11 held, A0=3,B0=5, A1=-2,B1=9 -> first Done_Sig=2'b01 Product=15, next Done_Sig=2'b10 Product=16'hFFEE; requesters alternate while both held.
REQ-029 Operand stability: change A0/B0 to 8'hFF one cycle after LOAD -> Product still equals the originally latched operands' product.
REQ-030 Mid-operation reset: pulse RSTn low during CALC -> outputs zero at once, no Done_Sig; a new request afterwards completes with correct Product.
REQ-031 Parameter sweep: CALC_CYCLES=1 and 15 -> Done_Sig at k+3 and k+17 respectively, results identical to the CALC_CYCLES=2 run.

Source files
------------

// File: rtl/booth_multiplier_arbiter_module.sv
// ---------------------------------------------------------------------------
// booth_multiplier_arbiter_module
//
// Purpose:
//   Two requesters share one combinational 8x8 signed radix-2 Booth
//   multiplier. A small FSM does the following for each operation:
//     - picks one requester, using round-robin when both request at once;
//     - latches that requester's operands;
//     - holds the operands stable for CALC_CYCLES cycles;
//     - captures the 16-bit product;
//     - pulses Done_Sig for the served requester;
//     - spends one CLEAR cycle before accepting the next request.
//
// Parameters:
//   CALC_CYCLES  cycles the operands sit at the multiplier before the
//                product is captured (1..15)
//
// Ports:
//   CLK        system clock, rising edge
//   RSTn       asynchronous active-low reset
//   Start_Sig  [1:0]  request level per requester
//   A0, B0     [7:0]  requester 0 signed operands
//   A1, B1     [7:0]  requester 1 signed operands
//   Done_Sig   [1:0]  one-cycle completion pulse to the served requester
//   Product    [15:0] registered signed product of the last operation
//   Busy              high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module booth_multiplier_arbiter_module #(
    parameter int CALC_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [1:0]  Start_Sig,
    input  logic [7:0]  A0,
    input  logic [7:0]  B0,
    input  logic [7:0]  A1,
    input  logic [7:0]  B1,
    output logic [1:0]  Done_Sig,
    output logic [15:0] Product,
    output logic        Busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        DONE,
        CLEAR
    } state_t;

    // Counter value seen on the last CALC cycle.
    localparam logic [3:0] CNT_LAST = 4'(CALC_CYCLES - 1);

    state_t      state;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  calc_cnt;
    logic        grant;
    logic        rr_last;
    logic        pick;
    logic [15:0] booth_prod;
    logic [15:0] mcand_ext;
    logic [8:0]  b_ext;

    // On a tie, the requester that was not served last wins.
    // A single request always goes to the requester that asked.
    always_comb begin
        pick = (Start_Sig == 2'b11) ? ~rr_last : Start_Sig[1];
    end

    // Radix-2 Booth recoding.
    // Each adjacent pair (b[i], b[i-1]) adds, subtracts or skips the
    // multiplicand shifted left by i. The implicit b[-1] is zero.
    // Working modulo 2^16 gives the exact signed 16-bit product.
    always_comb begin
        mcand_ext  = {{8{op_a[7]}}, op_a};
        b_ext      = {op_b, 1'b0};
        booth_prod = '0;
        for (int i = 0; i < 8; i++) begin
            case ({b_ext[i+1], b_ext[i]})
                2'b10:   booth_prod = booth_prod - (mcand_ext << i);
                2'b01:   booth_prod = booth_prod + (mcand_ext << i);
                default: booth_prod = booth_prod;
            endcase
        end
    end

    // Main control FSM. All outputs are registered here.
    // Busy and Done_Sig are set on the transition into the state they
    // describe, so they line up exactly with the state register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            calc_cnt <= '0;
            grant    <= 1'b0;
            rr_last  <= 1'b1;
            Done_Sig <= 2'b00;
            Product  <= '0;
            Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|Start_Sig) begin
                        grant <= pick;
                        Busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    op_a     <= grant ? A1 : A0;
                    op_b     <= grant ? B1 : B0;
                    calc_cnt <= '0;
                    state    <= CALC;
                end
                CALC: begin
                    calc_cnt <= calc_cnt + 4'd1;
                    if (calc_cnt == CNT_LAST) begin
                        Product  <= booth_prod;
                        Done_Sig <= grant ? 2'b10 : 2'b01;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    rr_last  <= grant;
                    Done_Sig <= 2'b00;
                    state    <= CLEAR;
                end
                CLEAR: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Done_Sig <= 2'b00;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier_arbiter_module.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier_arbiter_module
//
// Purpose:
//   Self-checking bench. It builds three copies of the arbiter with
//   CALC_CYCLES = 1, 2 and 15. All copies share the clock, the reset and
//   the operand buses. Each copy has its own Start_Sig.
//
//   A reference model predicts, for every transaction:
//     - which requester wins (round-robin memory of who was served last);
//     - the signed product, computed with plain integer arithmetic;
//     - the edge on which Done_Sig shows up.
//
//   Done_Sig is high in the cycle that ends at edge k+2+CALC_CYCLES.
//   So it is first seen just after edge k+1+CALC_CYCLES.
// ---------------------------------------------------------------------------
module tb_booth_multiplier_arbiter_module;

    logic        CLK;
    logic        RSTn;
    logic [1:0]  start_r [3];
    logic [7:0]  A0, B0, A1, B1;
    logic [1:0]  done_w  [3];
    logic [15:0] prod_w  [3];
    logic        busy_w  [3];

    int cc_tab [3] = '{1, 2, 15};
    int last_served [3];
    int checks = 0;
    int passed = 0;

    booth_multiplier_arbiter_module #(.CALC_CYCLES(1)) u_dut_c1 (
        .CLK(CLK), .RSTn(RSTn), .Start_Sig(start_r[0]),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Done_Sig(done_w[0]), .Product(prod_w[0]), .Busy(busy_w[0])
    );

    booth_multiplier_arbiter_module #(.CALC_CYCLES(2)) u_dut_c2 (
        .CLK(CLK), .RSTn(RSTn), .Start_Sig(start_r[1]),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Done_Sig(done_w[1]), .Product(prod_w[1]), .Busy(busy_w[1])
    );

    booth_multiplier_arbiter_module #(.CALC_CYCLES(15)) u_dut_c15 (
        .CLK(CLK), .RSTn(RSTn), .Start_Sig(start_r[2]),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Done_Sig(done_w[2]), .Product(prod_w[2]), .Busy(busy_w[2])
    );

    // Free-running 100 MHz-style clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One comparison. Every call counts toward the summary line.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive operands and one copy's request lines.
    task automatic applyStimulus(input int d, input logic [1:0] req,
                                 input logic [7:0] a0v, input logic [7:0] b0v,
                                 input logic [7:0] a1v, input logic [7:0] b1v);
        A0 = a0v;
        B0 = b0v;
        A1 = a1v;
        B1 = b1v;
        start_r[d] = req;
    endtask

    // Reset every copy, check the cleared outputs, and reset the model.
    task automatic doReset();
        RSTn = 1'b0;
        for (int d = 0; d < 3; d++) start_r[d] = 2'b00;
        repeat (2) @(posedge CLK);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("reset_done", done_w[d], 2'b00);
            checkOutput("reset_product", prod_w[d], 16'h0000);
            checkOutput("reset_busy", busy_w[d], 1'b0);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int d = 0; d < 3; d++) last_served[d] = 1;
    endtask

    // Serve one request on copy d, which must be idle on entry.
    // The model decides the winner and the product from the current
    // inputs. Optional behaviours:
    //   corrupt    - overwrite every operand bus to 8'hFF one cycle after
    //                the load;
    //   drop_early - release the request right after it is sampled.
    task automatic runTransaction(input int d, input bit corrupt,
                                  input bit drop_early);
        int          g;
        int          av;
        int          bv;
        int          n;
        logic [15:0] exp_prod;
        logic [1:0]  exp_done;

        if (start_r[d] == 2'b11) g = (last_served[d] == 0) ? 1 : 0;
        else                     g = (start_r[d] == 2'b10) ? 1 : 0;
        av = (g == 1) ? int'($signed(A1)) : int'($signed(A0));
        bv = (g == 1) ? int'($signed(B1)) : int'($signed(B0));
        exp_prod = 16'(av * bv);
        exp_done = (g == 1) ? 2'b10 : 2'b01;

        @(posedge CLK);
        #1;
        checkOutput("busy_after_sample", busy_w[d], 1'b1);
        if (drop_early) start_r[d] = 2'b00;

        // Wait for Done_Sig, but give up after a fixed cycle budget.
        n = 0;
        while (n < 40) begin
            @(posedge CLK);
            #1;
            n++;
            if (corrupt && n == 1) begin
                A0 = 8'hFF;
                B0 = 8'hFF;
                A1 = 8'hFF;
                B1 = 8'hFF;
            end
            if (done_w[d] != 2'b00) break;
        end
        checkOutput("done_latency", n, cc_tab[d] + 1);
        checkOutput("done_bits", done_w[d], exp_done);
        checkOutput("product", prod_w[d], exp_prod);
        last_served[d] = g;

        @(posedge CLK);
        #1;
        checkOutput("done_one_cycle", done_w[d], 2'b00);
        checkOutput("product_hold", prod_w[d], exp_prod);
        @(posedge CLK);
        #1;
        checkOutput("busy_back_idle", busy_w[d], 1'b0);
    endtask

    // Directed sequence, repeated on each CALC_CYCLES copy, then random
    // traffic across all copies.
    initial begin
        RSTn = 1'b0;
        A0 = '0;
        B0 = '0;
        A1 = '0;
        B1 = '0;
        for (int d = 0; d < 3; d++) start_r[d] = 2'b00;

        for (int d = 0; d < 3; d++) begin
            $display("[TB] directed sequence, CALC_CYCLES=%0d", cc_tab[d]);
            doReset();

            // Tie right after reset: requester 0 wins first, then they
            // alternate while both requests stay high.
            applyStimulus(d, 2'b11, 8'd3, 8'd5, 8'hFE, 8'd9);
            runTransaction(d, 1'b0, 1'b0);
            runTransaction(d, 1'b0, 1'b0);
            runTransaction(d, 1'b0, 1'b0);
            start_r[d] = 2'b00;

            applyStimulus(d, 2'b01, 8'd7, 8'd6, 8'd0, 8'd0);
            runTransaction(d, 1'b0, 1'b0);

            // Signed corner products.
            applyStimulus(d, 2'b10, 8'd0, 8'd0, 8'h80, 8'h80);
            runTransaction(d, 1'b0, 1'b0);
            applyStimulus(d, 2'b10, 8'd0, 8'd0, 8'h80, 8'h7F);
            runTransaction(d, 1'b0, 1'b0);
            applyStimulus(d, 2'b01, 8'hFF, 8'h01, 8'd0, 8'd0);
            runTransaction(d, 1'b0, 1'b0);
            applyStimulus(d, 2'b01, 8'h00, 8'h80, 8'd0, 8'd0);
            runTransaction(d, 1'b0, 1'b0);

            // Operands must not change the result once they are latched.
            applyStimulus(d, 2'b01, 8'h9C, 8'h4D, 8'd0, 8'd0);
            runTransaction(d, 1'b1, 1'b0);

            // The request is dropped early, but Done_Sig must still pulse.
            applyStimulus(d, 2'b10, 8'd0, 8'd0, 8'd11, 8'hF3);
            runTransaction(d, 1'b0, 1'b1);
            start_r[d] = 2'b00;
        end

        // Reset in the middle of CALC on the CALC_CYCLES=2 copy.
        // Outputs must clear at once and Done_Sig must never appear.
        applyStimulus(1, 2'b01, 8'd12, 8'd12, 8'd0, 8'd0);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("busy_in_calc", busy_w[1], 1'b1);
        RSTn = 1'b0;
        #1;
        checkOutput("midreset_done", done_w[1], 2'b00);
        checkOutput("midreset_product", prod_w[1], 16'h0000);
        checkOutput("midreset_busy", busy_w[1], 1'b0);
        start_r[1] = 2'b00;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("midreset_no_done", done_w[1], 2'b00);
        @(negedge CLK);
        RSTn = 1'b1;
        for (int d = 0; d < 3; d++) last_served[d] = 1;
        applyStimulus(1, 2'b11, 8'hF6, 8'd13, 8'd4, 8'd4);
        runTransaction(1, 1'b0, 1'b0);
        start_r[1] = 2'b00;

        // Random traffic: any copy, any request pattern, any operands.
        for (int it = 0; it < 30; it++) begin
            int         d;
            logic [1:0] req;
            d   = int'($urandom_range(0, 2));
            req = 2'($urandom_range(1, 3));
            applyStimulus(d, req, 8'($urandom), 8'($urandom),
                          8'($urandom), 8'($urandom));
            runTransaction(d, 1'b0, 1'b0);
            start_r[d] = 2'b00;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
